// File: rtl/prog_delay_buffer_pkg.sv
// Shared widths, helper functions and control bundle for the programmable delay buffer.
package prog_delay_buffer_pkg;

   function automatic int len_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   typedef struct packed {
      logic flush;
      logic cfg_we;
      logic en;
   } dly_ctrl_t;

endpackage

// File: rtl/prog_delay_buffer_if.sv
// Stream and configuration bundle between the operand feeder and the delay buffer.
interface prog_delay_buffer_if
   import prog_delay_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int BITS  = 64,
   parameter int LANES = 1
);
   localparam int LW = len_w(DEPTH);
   localparam int W  = LANES * BITS;

   logic          en;
   logic          flush;
   logic          cfg_we;
   logic [LW-1:0] cfg_len;
   logic [W-1:0]  d;
   logic [W-1:0]  q;
   logic          q_valid;
   logic [LW-1:0] fill;
   logic [LW-1:0] len;
   logic          cfg_err;

   modport master (
      output en, flush, cfg_we, cfg_len, d,
      input  q, q_valid, fill, len, cfg_err
   );

   modport slave (
      input  en, flush, cfg_we, cfg_len, d,
      output q, q_valid, fill, len, cfg_err
   );

endinterface

// File: rtl/delay_buf_ram.sv
// Delay-line storage: one synchronous write port, one combinational read port, contents not reset.
module delay_buf_ram #(
   parameter int DEPTH = 8,
   parameter int W     = 64,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_buffer.sv
// Programmable-length delay line: q shows the word shifted in exactly len enables earlier.
module prog_delay_buffer
   import prog_delay_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int BITS  = 64,
   parameter int LANES = 1
) (
   input  logic                clk,
   input  logic                rst,
   prog_delay_buffer_if.slave  bus
);

   localparam int LW = len_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int W  = LANES * BITS;

   localparam logic [PW-1:0] WP_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   dly_ctrl_t     ctrl;
   logic          cfg_legal;
   logic          wr_en;
   logic [PW-1:0] wp;
   logic [PW-1:0] rd;
   logic [LW-1:0] wp_l;
   logic [LW-1:0] gap;
   logic [LW-1:0] fill;
   logic [LW-1:0] len;
   logic          cfg_err;
   logic          q_valid;
   logic [W-1:0]  rdata;

   assign ctrl      = '{flush: bus.flush, cfg_we: bus.cfg_we, en: bus.en};
   assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= DEPTH_L);
   assign wr_en     = ctrl.en && !ctrl.flush;

   // Non-power-of-two depths need an explicit wrap rather than natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
      end else if (ctrl.flush) begin
         wp <= '0;
      end else if (ctrl.en) begin
         wp <= (wp == WP_LAST) ? '0 : wp + 1'b1;
      end
   end

   // A legal reprogram restarts the fill count even when a flush lands in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill    <= '0;
         len     <= DEPTH_L;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= ctrl.cfg_we && !cfg_legal;
         if (ctrl.cfg_we && cfg_legal) begin
            len <= bus.cfg_len;
         end
         if (ctrl.flush || (ctrl.cfg_we && cfg_legal)) begin
            fill <= '0;
         end else if (ctrl.en && (fill < len)) begin
            fill <= fill + 1'b1;
         end
      end
   end

   assign wp_l = LW'(wp);
   assign gap  = DEPTH_L - len;
   assign rd   = (wp_l >= len) ? PW'(wp_l - len) : PW'(wp_l + gap);

   delay_buf_ram #(
      .DEPTH (DEPTH),
      .W     (W),
      .AW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wp),
      .wdata (bus.d),
      .raddr (rd),
      .rdata (rdata)
   );

   assign q_valid     = (fill == len);
   assign bus.q       = q_valid ? rdata : '0;
   assign bus.q_valid = q_valid;
   assign bus.fill    = fill;
   assign bus.len     = len;
   assign bus.cfg_err = cfg_err;

endmodule
